// File: rtl/ram2flash_if.sv
// Streams a block of 32-bit code-RAM words to a byte-wide flash writer,
// lane 0 first, with a valid/ready handshake and an idle gap after every byte.
module ram2flash_if #(
   parameter int IMEM_WIDTH = 19,
   parameter int BYTE_GAP   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [IMEM_WIDTH-1:0] base_addr,
   input  logic [IMEM_WIDTH:0]   word_num,
   output logic [IMEM_WIDTH-1:0] ram_addr,
   output logic                  ram_ren,
   input  logic [7:0]            ram0_dout,
   input  logic [7:0]            ram1_dout,
   input  logic [7:0]            ram2_dout,
   input  logic [7:0]            ram3_dout,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           byte_cnt
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SEND, GAP, FINISH} state_t;

   // With no gap configured, GAP still lasts one cycle between bytes of a word
   // so tx_valid can drop after each accepted byte.
   localparam int              GAP_W    = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((BYTE_GAP > 1) ? BYTE_GAP - 1 : 0);
   localparam bit              NO_GAP   = (BYTE_GAP == 0);

   state_t                  state, state_nx;
   logic [IMEM_WIDTH:0]     words_left;
   logic [31:0]             word_reg;
   logic [1:0]              byte_idx;
   logic [GAP_W-1:0]        gap_cnt;
   logic                    accept, gap_end, word_end, last_byte, advance;

   assign word_end  = (byte_idx == 2'd3);
   assign last_byte = word_end && (words_left == (IMEM_WIDTH+1)'(1));
   assign accept    = (state == SEND) && tx_ready && !abort;
   assign gap_end   = (state == GAP) && !abort && (gap_cnt == GAP_LAST);
   assign advance   = word_end && (gap_end || (accept && NO_GAP && !last_byte));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      // NOTE: default assignment first so every path drives state_nx; no latch.
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (word_num == '0) ? FINISH : RD_REQ;
         RD_REQ:  state_nx = RD_WAIT;
         RD_WAIT: state_nx = SEND;
         SEND:    if (accept) state_nx = last_byte ? FINISH :
                                         (NO_GAP && word_end) ? RD_REQ : GAP;
         GAP:     if (gap_end) state_nx = word_end ? RD_REQ : SEND;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort && (state != IDLE)) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the word register is a plain flop, so clearing it on reset is cheap
      // and keeps tx_data at zero out of reset.
      if (!rst_n) begin
         ram_addr   <= '0;
         words_left <= '0;
         word_reg   <= '0;
         byte_idx   <= '0;
         gap_cnt    <= '0;
         byte_cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         if ((state == IDLE) && start) begin
            byte_cnt <= '0;
            if (word_num != '0) begin
               ram_addr   <= base_addr;
               words_left <= word_num;
            end
         end
         if ((state == RD_WAIT) && !abort) begin
            word_reg <= {ram3_dout, ram2_dout, ram1_dout, ram0_dout};
            byte_idx <= '0;
         end
         if (accept) begin
            byte_cnt <= byte_cnt + 32'd1;
            gap_cnt  <= '0;
         end
         if ((state == GAP) && !abort && !gap_end) gap_cnt <= gap_cnt + 1'b1;
         if (gap_end && !word_end) byte_idx <= byte_idx + 2'd1;
         if (advance) begin
            ram_addr   <= ram_addr + 1'b1;
            words_left <= words_left - 1'b1;
         end
      end
   end

   always_comb begin
      ram_ren  = (state == RD_REQ);
      tx_valid = (state == SEND);
      busy     = (state == RD_REQ) || (state == RD_WAIT) || (state == SEND) || (state == GAP);
      done     = (state == FINISH);
      case (byte_idx)
         2'd0:    tx_data = word_reg[7:0];
         2'd1:    tx_data = word_reg[15:8];
         2'd2:    tx_data = word_reg[23:16];
         default: tx_data = word_reg[31:24];
      endcase
   end

endmodule
